// File: rtl/song_player_pkg.sv
// Shared definitions for the song player: controller state codes, player FSM
// encoding, note-entry layout and the end-of-song marker.
package song_player_pkg;

    localparam logic [1:0] GAME_START  = 2'd0;
    localparam logic [1:0] GAME_MENU   = 2'd1;
    localparam logic [1:0] GAME_PLAY   = 2'd2;
    localparam logic [1:0] GAME_FINISH = 2'd3;

    localparam int DUR_W = 3;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_FETCH = 2'd1,
        P_PLAY  = 2'd2,
        P_DONE  = 2'd3
    } player_state_t;

    // End-of-song marker is the all-ones note code for the given code width.
    function automatic int note_end(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Note tables for songs 1..3 with a registered read port.
// Entries are {dur, note}; anything outside a song's region reads as the end marker.
module song_rom
    import song_player_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 6
) (
    input  logic                    clk,
    input  logic [1:0]              song_id,
    input  logic [ADDR_W-1:0]       addr,
    output logic [DUR_W+NOTE_W-1:0] entry
);

    localparam int ENTRY_W = DUR_W + NOTE_W;
    localparam logic [ENTRY_W-1:0] END_ENTRY = {{DUR_W{1'b0}}, NOTE_W'(note_end(NOTE_W))};

    function automatic logic [ENTRY_W-1:0] mk(input int dur, input int code);
        return {DUR_W'(dur), NOTE_W'(code)};
    endfunction

    always_ff @(posedge clk) begin
        entry <= END_ENTRY;
        case (song_id)
            2'd1: begin
                case (int'(addr))
                    0:       entry <= mk(0, 5);
                    1:       entry <= mk(1, 7);
                    default: ;
                endcase
            end
            2'd2: begin
                case (int'(addr))
                    0:       entry <= mk(2, 3);
                    1:       entry <= mk(0, 0);
                    2:       entry <= mk(1, 12);
                    default: ;
                endcase
            end
            // Song 3 fills the first four slots so a 2-bit table has no room for a marker.
            2'd3: begin
                case (int'(addr))
                    0:       entry <= mk(0, 9);
                    1:       entry <= mk(1, 10);
                    2:       entry <= mk(0, 11);
                    3:       entry <= mk(2, 20);
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/song_player.sv
// Plays the selected song's note table at a fixed beat rate while the game is in PLAY,
// and raises finish at the end of the song.
module song_player
    import song_player_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 3_125_000,
    parameter int ADDR_W         = 8,
    parameter int NOTE_W         = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state,
    input  logic [1:0]        song_select,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              beat_pulse,
    output logic [ADDR_W-1:0] progress,
    output logic              finish
);

    localparam int TICK_W = $clog2(TICKS_PER_BEAT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

    player_state_t cur, nxt;

    logic [1:0]              song_id;
    logic [ADDR_W-1:0]       addr;
    logic [TICK_W-1:0]       tick;
    logic [DUR_W-1:0]        beats_left;
    logic                    fetch_wait;
    logic [DUR_W+NOTE_W-1:0] rom_entry;
    logic [DUR_W-1:0]        entry_dur;
    logic [NOTE_W-1:0]       entry_code;
    logic                    entry_is_end;
    logic                    playing;
    logic                    beat_end;

    song_rom #(
        .ADDR_W (ADDR_W),
        .NOTE_W (NOTE_W)
    ) u_rom (
        .clk     (clk),
        .song_id (song_id),
        .addr    (addr),
        .entry   (rom_entry)
    );

    assign entry_dur    = rom_entry[DUR_W+NOTE_W-1 -: DUR_W];
    assign entry_code   = rom_entry[NOTE_W-1:0];
    assign entry_is_end = (entry_code == NOTE_W'(note_end(NOTE_W)));
    assign playing      = (state == GAME_PLAY);
    assign beat_end     = (tick == TICK_LAST);
    assign progress     = addr;

    always_ff @(posedge clk) begin
        if (rst) cur <= P_IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            P_IDLE: begin
                if (playing && song_select != 2'd0) nxt = P_FETCH;
            end
            P_FETCH: begin
                if (!playing)        nxt = P_IDLE;
                else if (fetch_wait) nxt = entry_is_end ? P_DONE : P_PLAY;
            end
            P_PLAY: begin
                if (!playing)                                nxt = P_IDLE;
                else if (beat_end && beats_left == '0) nxt = (addr == '1) ? P_DONE : P_FETCH;
            end
            P_DONE: begin
                if (!playing) nxt = P_IDLE;
            end
            default: nxt = P_IDLE;
        endcase
    end

    // FETCH spends one cycle addressing the ROM and captures its word on the second.
    always_ff @(posedge clk) begin
        if (rst) begin
            song_id    <= '0;
            addr       <= '0;
            tick       <= '0;
            beats_left <= '0;
            fetch_wait <= 1'b0;
            note       <= '0;
            note_valid <= 1'b0;
            beat_pulse <= 1'b0;
            finish     <= 1'b0;
        end else begin
            beat_pulse <= 1'b0;
            if (cur != P_IDLE && !playing) begin
                addr       <= '0;
                tick       <= '0;
                beats_left <= '0;
                fetch_wait <= 1'b0;
                note       <= '0;
                note_valid <= 1'b0;
                finish     <= 1'b0;
            end else begin
                case (cur)
                    P_IDLE: begin
                        if (nxt == P_FETCH) begin
                            song_id    <= song_select;
                            addr       <= '0;
                            tick       <= '0;
                            fetch_wait <= 1'b0;
                        end
                    end
                    P_FETCH: begin
                        if (!fetch_wait) begin
                            fetch_wait <= 1'b1;
                        end else begin
                            fetch_wait <= 1'b0;
                            tick       <= '0;
                            if (entry_is_end) begin
                                note       <= '0;
                                note_valid <= 1'b0;
                                finish     <= 1'b1;
                            end else begin
                                note       <= entry_code;
                                beats_left <= entry_dur;
                                note_valid <= 1'b1;
                            end
                        end
                    end
                    P_PLAY: begin
                        if (beat_end) begin
                            tick       <= '0;
                            beat_pulse <= 1'b1;
                            if (beats_left == '0) begin
                                if (addr == '1) begin
                                    note       <= '0;
                                    note_valid <= 1'b0;
                                    finish     <= 1'b1;
                                end else begin
                                    addr <= addr + 1'b1;
                                end
                            end else begin
                                beats_left <= beats_left - 1'b1;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_player.sv
// Randomised bench for song_player: two instances (8-bit and 2-bit note tables) compared
// every cycle against a schedule computed from the song tables.
module tb_song_player;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [1:0] song_select;

    logic [5:0] note_a, note_b;
    logic       valid_a, valid_b, pulse_a, pulse_b, fin_a, fin_b;
    logic [7:0] prog_a;
    logic [1:0] prog_b;

    int tests = 0;
    int fails = 0;

    int cycle  = 0;
    bit active = 1'b0;
    int start  = 0;
    int song   = 0;

    // Song tables as the bench knows them; -1 marks the end of a song.
    int tnote [1:3][0:4] = '{'{5, 7, -1, -1, -1}, '{3, 0, 12, -1, -1}, '{9, 10, 11, 20, -1}};
    int tdur  [1:3][0:4] = '{'{0, 1, 0, 0, 0},    '{2, 0, 1, 0, 0},    '{0, 1, 0, 2, 0}};

    typedef struct packed {
        int note;
        int valid;
        int pulse;
        int progress;
        int finish;
    } exp_t;

    song_player #(.TICKS_PER_BEAT(T), .ADDR_W(8), .NOTE_W(6)) dut_a (
        .clk(clk), .rst(rst), .state(state), .song_select(song_select),
        .note(note_a), .note_valid(valid_a), .beat_pulse(pulse_a),
        .progress(prog_a), .finish(fin_a)
    );

    song_player #(.TICKS_PER_BEAT(T), .ADDR_W(2), .NOTE_W(6)) dut_b (
        .clk(clk), .rst(rst), .state(state), .song_select(song_select),
        .note(note_b), .note_valid(valid_b), .beat_pulse(pulse_b),
        .progress(prog_b), .finish(fin_b)
    );

    always #5 clk = ~clk;

    // Expected outputs k cycles after the edge that started playback of song s.
    function automatic exp_t expect_at(input int s, input int amax, input int k);
        exp_t e;
        int   st, fin_t, n, d;
        e = '{0, 0, 0, 0, 0};
        if (k < 2) return e;
        st = 2;
        for (int i = 0; i < 16; i++) begin
            n = (i < 5) ? tnote[s][i] : -1;
            d = (i < 5) ? tdur[s][i] : 0;
            if (n < 0) begin
                e.finish = 1; e.progress = i;
                return e;
            end
            fin_t = st + (d + 1) * T;
            if (k > st && k <= fin_t && (k - st) % T == 0) e.pulse = 1;
            if (k < fin_t) begin
                e.note = n; e.valid = 1; e.progress = i;
                return e;
            end
            if (i == amax) begin
                e.finish = 1; e.progress = i;
                return e;
            end
            if (k < fin_t + 2) begin
                e.note = n; e.valid = 1; e.progress = i + 1;
                return e;
            end
            st = fin_t + 2;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, obs, exp);
        end
    endtask

    task automatic modelStep();
        cycle++;
        if (rst) begin
            active = 1'b0;
        end else if (!active) begin
            if (state == 2'd2 && song_select != 2'd0) begin
                active = 1'b1;
                start  = cycle;
                song   = int'(song_select);
            end
        end else if (state != 2'd2) begin
            active = 1'b0;
        end
    endtask

    task automatic checkAll();
        exp_t ea, eb;
        ea = '{0, 0, 0, 0, 0};
        eb = '{0, 0, 0, 0, 0};
        if (active) begin
            ea = expect_at(song, 255, cycle - start);
            eb = expect_at(song, 3, cycle - start);
        end
        checkOutput("A.note",     32'(note_a),  ea.note);
        checkOutput("A.valid",    32'(valid_a), ea.valid);
        checkOutput("A.pulse",    32'(pulse_a), ea.pulse);
        checkOutput("A.progress", 32'(prog_a),  ea.progress);
        checkOutput("A.finish",   32'(fin_a),   ea.finish);
        checkOutput("B.note",     32'(note_b),  eb.note);
        checkOutput("B.valid",    32'(valid_b), eb.valid);
        checkOutput("B.pulse",    32'(pulse_b), eb.pulse);
        checkOutput("B.progress", 32'(prog_b),  eb.progress);
        checkOutput("B.finish",   32'(fin_b),   eb.finish);
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] st, input logic [1:0] sl, input int n);
        for (int c = 0; c < n; c++) begin
            rst         = r;
            state       = st;
            song_select = sl;
            @(posedge clk);
            #1;
            modelStep();
            checkAll();
        end
    endtask

    initial begin
        rst         = 1'b1;
        state       = 2'd2;
        song_select = 2'd1;

        applyStimulus(1'b1, 2'd2, 2'd1, 3);
        applyStimulus(1'b0, 2'd2, 2'd1, 40);
        applyStimulus(1'b0, 2'd3, 2'd1, 2);
        applyStimulus(1'b0, 2'd2, 2'd1, 30);

        applyStimulus(1'b0, 2'd1, 2'd1, 2);
        applyStimulus(1'b0, 2'd2, 2'd1, 5);
        applyStimulus(1'b0, 2'd2, 2'd2, 30);

        applyStimulus(1'b0, 2'd1, 2'd0, 1);
        applyStimulus(1'b0, 2'd2, 2'd3, 12);
        applyStimulus(1'b0, 2'd1, 2'd3, 3);

        applyStimulus(1'b0, 2'd0, 2'd0, 1);
        applyStimulus(1'b0, 2'd2, 2'd3, 60);
        applyStimulus(1'b0, 2'd3, 2'd0, 1);
        applyStimulus(1'b0, 2'd2, 2'd2, 50);

        applyStimulus(1'b0, 2'd1, 2'd0, 1);
        applyStimulus(1'b0, 2'd2, 2'd0, 5);
        applyStimulus(1'b0, 2'd2, 2'd1, 7);
        applyStimulus(1'b1, 2'd2, 2'd1, 1);
        applyStimulus(1'b0, 2'd2, 2'd1, 10);

        for (int r = 0; r < 250; r++) begin
            logic       rs;
            logic [1:0] st, sl;
            int         n;
            rs = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            sl = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 40);
            applyStimulus(rs, st, sl, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
